// File: rtl/shift_sched_pkg.sv
// Shared types, constants and the round-robin pick used by the serial shift scheduler.
package shift_sched_pkg;

   // Default word width (bits per frame) and number of requesters.
   localparam int unsigned DEF_W = 8;
   localparam int unsigned DEF_N = 2;

   // Shift direction encoding carried per requester.
   localparam logic DIR_MSB = 1'b0;   // shift left, MSB leaves first
   localparam logic DIR_LSB = 1'b1;   // shift right, LSB leaves first

   // Widest request vector the round-robin pick accepts.
   localparam int unsigned RR_MAX   = 32;
   localparam int unsigned RR_IDX_W = $clog2(RR_MAX);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   // Round-robin pick: first set request bit searching upward (mod i_n)
   // starting one above i_last. Returns i_last when nothing is requested.
   function automatic int unsigned rr_pick(
      input logic [RR_MAX-1:0] i_req,
      input int unsigned       i_n,
      input int unsigned       i_last
   );
      int unsigned idx;
      logic        found;
      rr_pick = i_last;
      found   = 1'b0;
      for (int unsigned k = 1; k <= RR_MAX; k++) begin
         idx = (i_last + k) % i_n;
         if (!found && (k <= i_n) && i_req[idx[RR_IDX_W-1:0]]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/shift_sched_core.sv
// Parallel-load serial shifter: loads a word, then shifts one bit per enabled
// cycle toward the selected output end, back-filling with zeros.
module shift_core
   import shift_sched_pkg::*;
#(
   parameter int unsigned W = DEF_W
)(
   input  logic         clk,
   input  logic         rstn,
   input  logic         i_load,
   input  logic         i_en,
   input  logic         i_dir,
   input  logic [W-1:0] i_d,
   output logic         o_sout
);

   logic [W-1:0] r_shreg;

   // Shift register: load has priority over shifting; direction picks the fill end.
   // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would chain updates within one edge.
   // NOTE: the shifter is a handful of flops, not a RAM, so it is reset like any other register and reads 0 out of reset.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         r_shreg <= '0;
      end else if (i_load) begin
         r_shreg <= i_d;
      end else if (i_en) begin
         if (i_dir == DIR_LSB) begin
            r_shreg <= {1'b0, r_shreg[W-1:1]};
         end else begin
            r_shreg <= {r_shreg[W-2:0], 1'b0};
         end
      end
   end

   assign o_sout = (i_dir == DIR_LSB) ? r_shreg[0] : r_shreg[W-1];

endmodule

// File: rtl/shift_sched.sv
// Round-robin scheduler sharing one serial shifter among N parallel requesters.
// Grants one word at a time, streams it out over W cycles, pulses done, re-arbitrates.
module shift_sched
   import shift_sched_pkg::*;
#(
   parameter  int unsigned W   = DEF_W,
   parameter  int unsigned N   = DEF_N,
   localparam int unsigned IDW = $clog2(N),
   localparam int unsigned CW  = $clog2(W)
)(
   input  logic           clk,
   input  logic           rstn,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] req_data,
   input  logic [N-1:0]   req_dir,
   input  logic           abort,
   output logic [N-1:0]   gnt,
   output logic           busy,
   output logic           sout,
   output logic           sout_valid,
   output logic           sof,
   output logic           done,
   output logic [IDW-1:0] done_id
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDW-1:0]    r_last;
   logic [CW-1:0]     r_count;
   logic              r_dir;
   logic [N-1:0]      r_gnt;

   logic              w_load;
   logic              w_en;
   logic [RR_MAX-1:0] w_req_ext;
   int unsigned       w_pick;
   logic [IDW-1:0]    w_winner;
   logic [W-1:0]      w_word;
   logic              w_core_sout;

   // Widen the request vector to the pick function's fixed width.
   always_comb begin
      w_req_ext         = '0;
      w_req_ext[N-1:0]  = req;
   end

   assign w_pick   = rr_pick(w_req_ext, N, 32'(r_last));
   assign w_winner = IDW'(w_pick);
   assign w_word   = req_data[w_winner*W +: W];

   // State register.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and shifter control; arbitration only happens in IDLE.
   // NOTE: every output of this block is assigned a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_en        = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (|req) begin
               w_load      = 1'b1;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            w_en = 1'b1;
            if (abort) begin
               w_state_nxt = IDLE;
            end else if (r_count == CW'(W-1)) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Grant bookkeeping: winner, latched direction, bit counter and one-cycle grant pulse.
   // An abort never touches r_last, so the aborted requester keeps its rotation slot.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         r_last  <= IDW'(N-1);
         r_count <= '0;
         r_dir   <= DIR_MSB;
         r_gnt   <= '0;
      end else begin
         r_gnt <= w_load ? (N'(1) << w_winner) : '0;
         if (w_load) begin
            r_last  <= w_winner;
            r_count <= '0;
            r_dir   <= req_dir[w_winner];
         end else if (w_en) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   shift_core #(
      .W (W)
   ) u_core (
      .clk    (clk),
      .rstn   (rstn),
      .i_load (w_load),
      .i_en   (w_en),
      .i_dir  (r_dir),
      .i_d    (w_word),
      .o_sout (w_core_sout)
   );

   // Outputs decode registered state only.
   assign gnt        = r_gnt;
   assign busy       = (r_state != IDLE);
   assign sout_valid = (r_state == SHIFT);
   assign sof        = sout_valid && (r_count == '0);
   assign sout       = sout_valid & w_core_sout;
   assign done       = (r_state == DONE);
   assign done_id    = done ? r_last : '0;

endmodule

// File: tb/tb_shift_sched.sv
// Bench for shift_sched: table-driven frames, hand-written multi-cycle corner
// sequences, and a randomized run against a frame-level expected-output queue.
module tb_shift_sched;
   import shift_sched_pkg::*;

   localparam int unsigned W = 8;
   localparam int unsigned N = 2;

   logic           clk = 1'b0;
   logic           rstn;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_dir;
   logic           abort;
   logic [N-1:0]   gnt;
   logic           busy;
   logic           sout;
   logic           sout_valid;
   logic           sof;
   logic           done;
   logic [0:0]     done_id;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   shift_sched #(
      .W (W),
      .N (N)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req        (req),
      .req_data   (req_data),
      .req_dir    (req_dir),
      .abort      (abort),
      .gnt        (gnt),
      .busy       (busy),
      .sout       (sout),
      .sout_valid (sout_valid),
      .sof        (sof),
      .done       (done),
      .done_id    (done_id)
   );

   // Packed output view: {gnt[1:0], busy, sout, sout_valid, sof, done, done_id}
   function automatic logic [7:0] pk(input logic [1:0] g, input logic b, input logic s,
                                     input logic v, input logic f, input logic d, input logic id);
      return {g, b, s, v, f, d, id};
   endfunction

   // sout is only meaningful while sout_valid is high.
   function automatic logic [7:0] outs();
      return {gnt, busy, sout & sout_valid, sout_valid, sof, done, done_id[0]};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle", {7'b0, busy}, 8'h00);
   endtask

   // ---------------- directed frame table ----------------
   typedef struct {
      int unsigned id;
      logic [W-1:0] data;
      logic         dir;
      logic [W-1:0] seq;   // expected serial bits, first bit in seq[W-1]
   } frame_vec_t;

   frame_vec_t fv[6];

   task automatic run_frame(input frame_vec_t v);
      logic [1:0] oh;
      oh = 2'(1 << v.id);
      req = oh;
      req_data[v.id*W +: W] = v.data;
      req_dir[v.id] = v.dir;
      @(negedge clk);
      check("frame_first_bit", outs(), pk(oh, 1'b1, v.seq[W-1], 1'b1, 1'b1, 1'b0, 1'b0));
      req = '0;
      for (int b = 1; b < W; b++) begin
         @(negedge clk);
         check($sformatf("frame_bit%0d", b), outs(), pk(2'b00, 1'b1, v.seq[W-1-b], 1'b1, 1'b0, 1'b0, 1'b0));
      end
      @(negedge clk);
      check("frame_done", outs(), pk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, v.id[0]));
      @(negedge clk);
      check("frame_idle_after", outs(), 8'h00);
   endtask

   // ---------------- reference model ----------------
   // Expected outputs are queued a whole frame at a time when a grant is decided.
   logic [7:0]  exp_q[$];
   logic [7:0]  cur;
   int unsigned m_last;

   task automatic model_reset();
      exp_q.delete();
      m_last = N - 1;
      cur    = 8'h00;
   endtask

   task automatic model_step();
      int unsigned  win;
      logic         found;
      logic [W-1:0] d;
      logic         bitv;
      if (cur[3] && abort) begin
         exp_q.delete();
      end else if (cur == 8'h00 && req != '0) begin
         win   = m_last;
         found = 1'b0;
         for (int unsigned k = 1; k <= N; k++) begin
            if (!found && req[(m_last + k) % N]) begin
               win   = (m_last + k) % N;
               found = 1'b1;
            end
         end
         d = req_data[win*W +: W];
         for (int b = 0; b < W; b++) begin
            bitv = req_dir[win] ? d[b] : d[W-1-b];
            exp_q.push_back(pk((b == 0) ? 2'(1 << win) : 2'b00, 1'b1, bitv, 1'b1, (b == 0), 1'b0, 1'b0));
         end
         exp_q.push_back(pk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, win[0]));
         m_last = win;
      end
      cur = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
   endtask

   task automatic drive_random();
      for (int i = 0; i < N; i++) begin
         if (req[i]) begin
            if (cur[6+i] && $urandom_range(3, 0) != 0) req[i] = 1'b0;
         end else if ($urandom_range(2, 0) == 0) begin
            req[i] = 1'b1;
            req_data[i*W +: W] = W'($urandom);
            req_dir[i] = 1'($urandom_range(1, 0));
         end
      end
      abort = ($urandom_range(11, 0) == 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          gc[$];
      logic [1:0]  gv[$];
      int          ng;

      fv[0] = '{id: 0, data: 8'hA5, dir: DIR_MSB, seq: 8'b10100101};
      fv[1] = '{id: 1, data: 8'h01, dir: DIR_LSB, seq: 8'b10000000};
      fv[2] = '{id: 0, data: 8'h3C, dir: DIR_MSB, seq: 8'b00111100};
      fv[3] = '{id: 1, data: 8'h80, dir: DIR_LSB, seq: 8'b00000001};
      fv[4] = '{id: 0, data: 8'hC3, dir: DIR_LSB, seq: 8'b11000011};
      fv[5] = '{id: 1, data: 8'h6E, dir: DIR_LSB, seq: 8'b01110110};

      rstn     = 1'b1;
      req      = '0;
      req_data = '0;
      req_dir  = '0;
      abort    = 1'b0;
      #12;
      check("reset_state", outs(), 8'h00);
      @(negedge clk);
      rstn = 1'b0;

      // Table-driven single-requester frames, both directions.
      foreach (fv[i]) run_frame(fv[i]);

      // Late request: raised during DONE must wait for the IDLE edge.
      req = 2'b01;
      req_data[0 +: W] = 8'hF0;
      req_dir[0] = DIR_MSB;
      @(negedge clk);
      check("late_first", outs(), pk(2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
      req = '0;
      for (int b = 1; b < W; b++) begin
         @(negedge clk);
         check("late_bit", outs(), pk(2'b00, 1'b1, (b < 4), 1'b1, 1'b0, 1'b0, 1'b0));
      end
      req[1] = 1'b1;
      req_data[W +: W] = 8'h55;
      req_dir[1] = DIR_MSB;
      @(negedge clk);
      check("late_done_no_gnt", outs(), pk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      @(negedge clk);
      check("late_idle_no_gnt", outs(), 8'h00);
      @(negedge clk);
      check("late_gnt", outs(), pk(2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      req = '0;
      wait_idle();

      // Abort in frame cycle 3 of an all-ones word.
      req = 2'b01;
      req_data[0 +: W] = 8'hFF;
      req_dir[0] = DIR_MSB;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("abort_bit", outs(), pk((k == 0) ? 2'b01 : 2'b00, 1'b1, 1'b1, 1'b1, (k == 0), 1'b0, 1'b0));
         if (k == 0) req = '0;
      end
      abort = 1'b1;
      req   = 2'b11;
      @(negedge clk);
      check("abort_idle", outs(), 8'h00);
      abort = 1'b0;
      @(negedge clk);
      check("abort_next_gnt", outs(), pk(2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      req = 2'b01;
      wait_idle();
      @(negedge clk);
      check("abort_then_req0", outs(), pk(2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
      req = '0;
      wait_idle();

      // Reset mid-frame, then contention with both requests held.
      req = 2'b01;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (k == 0) req = '0;
      end
      #2 rstn = 1'b1;
      #1 check("async_reset", outs(), 8'h00);
      @(negedge clk);
      rstn = 1'b0;
      req  = 2'b11;
      for (int i = 1; i <= 45; i++) begin
         @(negedge clk);
         if (gnt != '0) begin
            gc.push_back(i);
            gv.push_back(gnt);
         end
      end
      check_int("cont_grant_count", gc.size(), 5);
      ng = (gc.size() < 4) ? gc.size() : 4;
      if (ng > 0) check_int("cont_first_cycle", gc[0], 1);
      for (int j = 0; j < ng; j++) begin
         check($sformatf("cont_gnt%0d", j), {6'b0, gv[j]}, (j % 2 == 0) ? 8'h01 : 8'h02);
         if (j > 0) check_int($sformatf("cont_gap%0d", j), gc[j] - gc[j-1], W + 2);
      end
      req = '0;
      wait_idle();

      // Randomized traffic against the frame-level model.
      @(negedge clk);
      rstn = 1'b1;
      model_reset();
      req   = '0;
      abort = 1'b0;
      @(negedge clk);
      rstn = 1'b0;
      for (int c = 0; c < 800; c++) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         check($sformatf("rand_cyc%0d", c), outs(), cur);
         drive_random();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
